// File: rtl/riscv_gdb_trigger_if.sv
// Bus bundle between the CPU/stub side and the trigger unit: table programming,
// IFU/LSU snoop inputs and the halt event handshake.
interface riscv_gdb_trigger_if #(
    parameter int XLEN    = 32,
    parameter int TRG_NUM = 4
);
    localparam int IW = (TRG_NUM > 1) ? $clog2(TRG_NUM) : 1;

    logic            cfg_wen;
    logic [IW-1:0]   cfg_idx;
    logic            cfg_ena;
    logic [1:0]      cfg_typ;
    logic [XLEN-1:0] cfg_adr;
    logic [XLEN-1:0] cfg_msk;
    logic            step_req;
    logic            ifu_trn;
    logic [XLEN-1:0] ifu_adr;
    logic            lsu_trn;
    logic [XLEN-1:0] lsu_adr;
    logic            lsu_wen;
    logic            hlt_vld;
    logic            hlt_rdy;
    logic [2:0]      hlt_cau;
    logic [IW-1:0]   hlt_idx;
    logic [XLEN-1:0] hlt_adr;
    logic            hlt_ovf;

    modport master (
        output cfg_wen, cfg_idx, cfg_ena, cfg_typ, cfg_adr, cfg_msk,
        output step_req, ifu_trn, ifu_adr, lsu_trn, lsu_adr, lsu_wen, hlt_rdy,
        input  hlt_vld, hlt_cau, hlt_idx, hlt_adr, hlt_ovf
    );

    modport slave (
        input  cfg_wen, cfg_idx, cfg_ena, cfg_typ, cfg_adr, cfg_msk,
        input  step_req, ifu_trn, ifu_adr, lsu_trn, lsu_adr, lsu_wen, hlt_rdy,
        output hlt_vld, hlt_cau, hlt_idx, hlt_adr, hlt_ovf
    );
endinterface

// File: rtl/riscv_gdb_trigger.sv
// Hardware breakpoint / watchpoint / single-step unit: snoops IFU and LSU buses
// against a trigger table and raises one held halt event for the debug stub.
module riscv_gdb_trigger #(
    parameter int XLEN    = 32,
    parameter int TRG_NUM = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    riscv_gdb_trigger_if.slave   bus
);
    localparam int IW = (TRG_NUM > 1) ? $clog2(TRG_NUM) : 1;

    localparam logic [1:0] TYP_EXE = 2'd0;
    localparam logic [1:0] TYP_WR  = 2'd1;
    localparam logic [1:0] TYP_RD  = 2'd2;
    localparam logic [1:0] TYP_ACC = 2'd3;

    localparam logic [2:0] CAU_BRK  = 3'd1;
    localparam logic [2:0] CAU_WR   = 3'd2;
    localparam logic [2:0] CAU_RD   = 3'd3;
    localparam logic [2:0] CAU_STEP = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STEP0 = 2'd1,
        ST_STEP1 = 2'd2,
        ST_PEND  = 2'd3
    } state_t;

    logic            ena_r [TRG_NUM];
    logic [1:0]      typ_r [TRG_NUM];
    logic [XLEN-1:0] adr_r [TRG_NUM];
    logic [XLEN-1:0] msk_r [TRG_NUM];

    state_t          state_r;
    state_t          state_nxt_s;
    logic            hlt_vld_r;
    logic [2:0]      hlt_cau_r;
    logic [IW-1:0]   hlt_idx_r;
    logic [XLEN-1:0] hlt_adr_r;
    logic            hlt_ovf_r;

    logic            exe_hit_s;
    logic [IW-1:0]   exe_idx_s;
    logic            lsu_hit_s;
    logic [IW-1:0]   lsu_idx_s;
    logic            hit_s;
    logic [2:0]      hit_cau_s;
    logic [IW-1:0]   hit_idx_s;
    logic [XLEN-1:0] hit_adr_s;

    logic            cap_s;
    logic [2:0]      cap_cau_s;
    logic [IW-1:0]   cap_idx_s;
    logic [XLEN-1:0] cap_adr_s;
    logic            ovf_set_s;

    function automatic logic adr_match(input logic [XLEN-1:0] bus_adr,
                                       input logic [XLEN-1:0] trg_adr,
                                       input logic [XLEN-1:0] trg_msk);
        return (((bus_adr ^ trg_adr) & ~trg_msk) == '0);
    endfunction

    // Trigger table; a write lands at the edge so same-cycle matches see the old entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < TRG_NUM; i++) begin
            if (rst) begin
                ena_r[i] <= 1'b0;
                typ_r[i] <= 2'd0;
                adr_r[i] <= '0;
                msk_r[i] <= '0;
            end else if (bus.cfg_wen && (bus.cfg_idx == IW'(i))) begin
                ena_r[i] <= bus.cfg_ena;
                typ_r[i] <= bus.cfg_typ;
                adr_r[i] <= bus.cfg_adr;
                msk_r[i] <= bus.cfg_msk;
            end
        end
    end

    // Per-entry compare; descending scan leaves the lowest hitting index selected.
    always_comb begin
        exe_hit_s = 1'b0;
        exe_idx_s = '0;
        lsu_hit_s = 1'b0;
        lsu_idx_s = '0;
        for (int i = TRG_NUM - 1; i >= 0; i--) begin
            if (ena_r[i] && bus.ifu_trn && (typ_r[i] == TYP_EXE) &&
                adr_match(bus.ifu_adr, adr_r[i], msk_r[i])) begin
                exe_hit_s = 1'b1;
                exe_idx_s = IW'(i);
            end else begin
                exe_hit_s = exe_hit_s;
            end
            if (ena_r[i] && bus.lsu_trn &&
                (((typ_r[i] == TYP_WR) && bus.lsu_wen) ||
                 ((typ_r[i] == TYP_RD) && !bus.lsu_wen) ||
                 (typ_r[i] == TYP_ACC)) &&
                adr_match(bus.lsu_adr, adr_r[i], msk_r[i])) begin
                lsu_hit_s = 1'b1;
                lsu_idx_s = IW'(i);
            end else begin
                lsu_hit_s = lsu_hit_s;
            end
        end
    end

    // Fetch triggers outrank data triggers within a cycle.
    always_comb begin
        hit_s     = exe_hit_s | lsu_hit_s;
        hit_cau_s = 3'd0;
        hit_idx_s = '0;
        hit_adr_s = '0;
        if (exe_hit_s) begin
            hit_cau_s = CAU_BRK;
            hit_idx_s = exe_idx_s;
            hit_adr_s = bus.ifu_adr;
        end else if (lsu_hit_s) begin
            hit_cau_s = bus.lsu_wen ? CAU_WR : CAU_RD;
            hit_idx_s = lsu_idx_s;
            hit_adr_s = bus.lsu_adr;
        end else begin
            hit_cau_s = 3'd0;
        end
    end

    // Next-state and capture decisions.
    always_comb begin
        state_nxt_s = state_r;
        cap_s       = 1'b0;
        cap_cau_s   = 3'd0;
        cap_idx_s   = '0;
        cap_adr_s   = '0;
        ovf_set_s   = 1'b0;
        case (state_r)
            ST_RUN, ST_STEP0, ST_STEP1: begin
                if (hit_s) begin
                    state_nxt_s = ST_PEND;
                    cap_s       = 1'b1;
                    cap_cau_s   = hit_cau_s;
                    cap_idx_s   = hit_idx_s;
                    cap_adr_s   = hit_adr_s;
                end else if ((state_r == ST_RUN) && bus.step_req) begin
                    state_nxt_s = ST_STEP0;
                end else if ((state_r == ST_STEP0) && bus.ifu_trn) begin
                    state_nxt_s = ST_STEP1;
                end else if ((state_r == ST_STEP1) && bus.ifu_trn) begin
                    state_nxt_s = ST_PEND;
                    cap_s       = 1'b1;
                    cap_cau_s   = CAU_STEP;
                    cap_adr_s   = bus.ifu_adr;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_PEND: begin
                ovf_set_s = hit_s | bus.step_req;
                if (bus.hlt_rdy) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_PEND;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // State and halt event registers; cause/index/address survive the accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_RUN;
            hlt_vld_r <= 1'b0;
            hlt_cau_r <= 3'd0;
            hlt_idx_r <= '0;
            hlt_adr_r <= '0;
            hlt_ovf_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            hlt_vld_r <= (state_nxt_s == ST_PEND);
            if (cap_s) begin
                hlt_cau_r <= cap_cau_s;
                hlt_idx_r <= cap_idx_s;
                hlt_adr_r <= cap_adr_s;
            end
            if (ovf_set_s) begin
                hlt_ovf_r <= 1'b1;
            end
        end
    end

    assign bus.hlt_vld = hlt_vld_r;
    assign bus.hlt_cau = hlt_cau_r;
    assign bus.hlt_idx = hlt_idx_r;
    assign bus.hlt_adr = hlt_adr_r;
    assign bus.hlt_ovf = hlt_ovf_r;
endmodule

// File: tb/tb_riscv_gdb_trigger.sv
// Directed bench for riscv_gdb_trigger: hand-computed halt events checked with
// immediate assertions one cycle after each stimulus step.
module tb_riscv_gdb_trigger;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    riscv_gdb_trigger_if #(.XLEN(32), .TRG_NUM(4)) bif ();

    riscv_gdb_trigger #(.XLEN(32), .TRG_NUM(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_hlt(input string tag, input logic vld, input logic [2:0] cau,
                           input logic [1:0] idx, input logic [31:0] adr);
        chk({tag, ".vld"}, 32'(bif.hlt_vld), 32'(vld));
        chk({tag, ".cau"}, 32'(bif.hlt_cau), 32'(cau));
        chk({tag, ".idx"}, 32'(bif.hlt_idx), 32'(idx));
        chk({tag, ".adr"}, bif.hlt_adr, adr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bif.cfg_wen  = 1'b0;
        bif.step_req = 1'b0;
        bif.ifu_trn  = 1'b0;
        bif.lsu_trn  = 1'b0;
        bif.lsu_wen  = 1'b0;
        bif.hlt_rdy  = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] idx, input logic ena, input logic [1:0] typ,
                           input logic [31:0] adr, input logic [31:0] msk);
        bif.cfg_wen = 1'b1;
        bif.cfg_idx = idx;
        bif.cfg_ena = ena;
        bif.cfg_typ = typ;
        bif.cfg_adr = adr;
        bif.cfg_msk = msk;
    endtask

    task automatic fetch(input logic [31:0] adr);
        bif.ifu_trn = 1'b1;
        bif.ifu_adr = adr;
    endtask

    task automatic lsu(input logic wen, input logic [31:0] adr);
        bif.lsu_trn = 1'b1;
        bif.lsu_wen = wen;
        bif.lsu_adr = adr;
    endtask

    task automatic accept();
        bif.hlt_rdy = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        idle();
        bif.cfg_idx = 2'd0;
        bif.cfg_ena = 1'b0;
        bif.cfg_typ = 2'd0;
        bif.cfg_adr = 32'd0;
        bif.cfg_msk = 32'd0;
        bif.ifu_adr = 32'd0;
        bif.lsu_adr = 32'd0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_hlt("reset", 1'b0, 3'd0, 2'd0, 32'd0);
        chk("reset.ovf", 32'(bif.hlt_ovf), 32'd0);

        // Exec breakpoint on 0x8000_0010
        set_cfg(2'd0, 1'b1, 2'd0, 32'h8000_0010, 32'd0);
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            fetch(32'h8000_0000 + 32'(k * 4));
            tick();
            chk("brk.pre", 32'(bif.hlt_vld), 32'd0);
        end
        fetch(32'h8000_0010);
        tick();
        idle();
        chk_hlt("brk", 1'b1, 3'd1, 2'd0, 32'h8000_0010);
        tick();
        chk_hlt("brk.hold", 1'b1, 3'd1, 2'd0, 32'h8000_0010);
        accept();
        chk_hlt("brk.acc", 1'b0, 3'd1, 2'd0, 32'h8000_0010);

        // Write watch on 0x100 with low two bits masked
        set_cfg(2'd2, 1'b1, 2'd1, 32'h0000_0100, 32'h0000_0003);
        tick();
        idle();
        lsu(1'b0, 32'h0000_0102);
        tick();
        idle();
        chk("wr.read", 32'(bif.hlt_vld), 32'd0);
        lsu(1'b1, 32'h0000_0102);
        tick();
        idle();
        chk_hlt("wr", 1'b1, 3'd2, 2'd2, 32'h0000_0102);
        accept();
        chk("wr.acc", 32'(bif.hlt_vld), 32'd0);

        // Single step: stepped fetch, then halt on the following fetch
        bif.step_req = 1'b1;
        tick();
        idle();
        chk("step.req", 32'(bif.hlt_vld), 32'd0);
        fetch(32'h8000_0020);
        tick();
        idle();
        chk("step.f0", 32'(bif.hlt_vld), 32'd0);
        fetch(32'h8000_0024);
        tick();
        idle();
        chk_hlt("step", 1'b1, 3'd4, 2'd0, 32'h8000_0024);
        accept();
        chk("step.acc", 32'(bif.hlt_vld), 32'd0);
        chk("step.ovf", 32'(bif.hlt_ovf), 32'd0);

        // Exec idx1 and access idx0 hitting together; then a dropped hit
        set_cfg(2'd1, 1'b1, 2'd0, 32'h8000_0040, 32'd0);
        tick();
        set_cfg(2'd0, 1'b1, 2'd3, 32'h0000_0200, 32'd0);
        tick();
        idle();
        fetch(32'h8000_0040);
        lsu(1'b0, 32'h0000_0200);
        tick();
        idle();
        chk_hlt("prio", 1'b1, 3'd1, 2'd1, 32'h8000_0040);
        lsu(1'b1, 32'h0000_0200);
        tick();
        idle();
        chk_hlt("drop", 1'b1, 3'd1, 2'd1, 32'h8000_0040);
        chk("drop.ovf", 32'(bif.hlt_ovf), 32'd1);
        accept();
        lsu(1'b0, 32'h0000_0200);
        tick();
        idle();
        chk_hlt("acc.rd", 1'b1, 3'd3, 2'd0, 32'h0000_0200);
        chk("ovf.sticky", 32'(bif.hlt_ovf), 32'd1);
        accept();

        // Disabling idx1 in the cycle of its hit still raises the halt
        set_cfg(2'd1, 1'b0, 2'd0, 32'h8000_0040, 32'd0);
        fetch(32'h8000_0040);
        tick();
        idle();
        chk_hlt("wen.same", 1'b1, 3'd1, 2'd1, 32'h8000_0040);
        accept();
        fetch(32'h8000_0040);
        tick();
        idle();
        chk("wen.after", 32'(bif.hlt_vld), 32'd0);

        // Fully masked read entry matches any address; reset during PEND
        set_cfg(2'd3, 1'b1, 2'd2, 32'd0, 32'hFFFF_FFFF);
        tick();
        idle();
        lsu(1'b0, 32'hDEAD_BEEF);
        tick();
        idle();
        chk_hlt("allmsk", 1'b1, 3'd3, 2'd3, 32'hDEAD_BEEF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_hlt("rst.pend", 1'b0, 3'd0, 2'd0, 32'd0);
        chk("rst.ovf", 32'(bif.hlt_ovf), 32'd0);
        lsu(1'b0, 32'hDEAD_BEEF);
        tick();
        idle();
        chk("rst.tbl.rd", 32'(bif.hlt_vld), 32'd0);
        fetch(32'h8000_0010);
        tick();
        idle();
        chk("rst.tbl.ex", 32'(bif.hlt_vld), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
